// File: rtl/hack_alu_ctrl_seq_if.sv
// Instruction fetch handshake between the instruction-memory side (master)
// and the Hack control sequencer (slave).
interface hack_alu_ctrl_seq_if #(
    parameter int unsigned PC_WIDTH = 15
);
    logic                instr_valid;
    logic [15:0]         instr;
    logic                instr_ready;
    logic [PC_WIDTH-1:0] pc;

    modport master (output instr_valid, output instr, input instr_ready, input pc);
    modport slave  (input instr_valid, input instr, output instr_ready, output pc);
endinterface

// File: rtl/hack_alu_ctrl_seq.sv
// Multi-cycle Hack CPU control sequencer: decodes one instruction per handshake,
// drives the external ALU, and updates A/D/PC and data memory.
module hack_alu_ctrl_seq #(
    parameter int unsigned         PC_WIDTH = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    hack_alu_ctrl_seq_if.slave  ifetch,
    input  logic [15:0]         inM,
    output logic [PC_WIDTH-1:0] addressM,
    output logic [15:0]         outM,
    output logic                writeM,
    output logic [15:0]         alu_x,
    output logic [15:0]         alu_y,
    output logic                alu_zx,
    output logic                alu_nx,
    output logic                alu_zy,
    output logic                alu_ny,
    output logic                alu_f,
    output logic                alu_no,
    input  logic [15:0]         alu_out,
    input  logic                alu_zr,
    input  logic                alu_ng,
    output logic                retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        WB
    } state_t;

    state_t              state;
    logic [15:0]         a_q;
    logic [15:0]         d_q;
    logic [15:0]         ir_q;
    logic [15:0]         r_q;
    logic                z_q;
    logic                n_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                ready_q;
    logic                write_q;
    logic                retired_q;
    logic [5:0]          ctrl_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                jump;

    assign pc_inc = pc_q + PC_WIDTH'(1);

    always_comb begin
        jump = (ir_q[2] & n_q) | (ir_q[1] & z_q) | (ir_q[0] & ~n_q & ~z_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            d_q       <= '0;
            ir_q      <= '0;
            r_q       <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            pc_q      <= RESET_PC;
            ready_q   <= 1'b0;
            write_q   <= 1'b0;
            retired_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    ready_q <= 1'b1;
                end
                FETCH: begin
                    if (ifetch.instr_valid && ready_q) begin
                        ir_q    <= ifetch.instr;
                        ready_q <= 1'b0;
                        // Controls are loaded on entry so they are valid for the whole EXEC cycle.
                        if (ifetch.instr[15]) begin
                            state  <= EXEC;
                            ctrl_q <= ifetch.instr[11:6];
                        end else begin
                            state     <= WB;
                            retired_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_q       <= alu_out;
                    z_q       <= alu_zr;
                    n_q       <= alu_ng;
                    ctrl_q    <= '0;
                    write_q   <= ir_q[3];
                    retired_q <= 1'b1;
                    state     <= WB;
                end
                WB: begin
                    write_q   <= 1'b0;
                    retired_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state     <= FETCH;
                    if (!ir_q[15]) begin
                        a_q  <= ir_q;
                        pc_q <= pc_inc;
                    end else begin
                        if (ir_q[5]) a_q <= r_q;
                        if (ir_q[4]) d_q <= r_q;
                        // Jump target is the A value from before this write-back.
                        pc_q <= jump ? a_q[PC_WIDTH-1:0] : pc_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ifetch.instr_ready = ready_q;
    assign ifetch.pc          = pc_q;
    assign addressM           = a_q[PC_WIDTH-1:0];
    assign outM               = r_q;
    assign writeM             = write_q;
    assign retired            = retired_q;
    assign alu_x              = d_q;
    assign alu_y              = (state == EXEC && ir_q[12]) ? inM : a_q;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl_q;

endmodule

// File: tb/tb_hack_alu_ctrl_seq.sv
// Scoreboard bench for hack_alu_ctrl_seq: an ISA-level Hack model predicts
// per-instruction results that are compared when the sequencer retires.
module tb_hack_alu_ctrl_seq;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [14:0] pc;
        logic        wr;
        logic [14:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] inM;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_zr, alu_ng;
    logic        retired;

    logic [15:0] mem       [256] = '{50: 16'd9, default: 16'h0000};
    logic [15:0] model_mem [256] = '{50: 16'd9, default: 16'h0000};

    logic [15:0] m_a = '0;
    logic [15:0] m_d = '0;
    logic [14:0] m_pc = '0;

    exp_t        sb[$];
    exp_t        post;
    bit          post_pending = 1'b0;
    int unsigned retire_cnt = 0;
    int unsigned wr_cnt = 0;
    logic [14:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    hack_alu_ctrl_seq_if #(.PC_WIDTH(15)) ifc ();

    hack_alu_ctrl_seq #(.PC_WIDTH(15), .RESET_PC(15'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ifetch   (ifc.slave),
        .inM      (inM),
        .addressM (addressM),
        .outM     (outM),
        .writeM   (writeM),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_zx   (alu_zx),
        .alu_nx   (alu_nx),
        .alu_zy   (alu_zy),
        .alu_ny   (alu_ny),
        .alu_f    (alu_f),
        .alu_no   (alu_no),
        .alu_out  (alu_out),
        .alu_zr   (alu_zr),
        .alu_ng   (alu_ng),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];
    assign inM     = mem[addressM[7:0]];

    always @(posedge clk) begin
        if (writeM) mem[addressM[7:0]] <= outM;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic [15:0] ins, output exp_t e);
        logic [15:0] y, o;
        logic        j;
        e.wr   = 1'b0;
        e.addr = m_a[14:0];
        e.data = '0;
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            y = ins[12] ? model_mem[m_a[7:0]] : m_a;
            o = hack_alu(m_d, y, ins[11:6]);
            e.wr   = ins[3];
            e.data = o;
            if (ins[3]) model_mem[m_a[7:0]] = o;
            j = (ins[2] && o[15]) || (ins[1] && o == 16'h0000) ||
                (ins[0] && !o[15] && o != 16'h0000);
            m_pc = j ? m_a[14:0] : m_pc + 15'd1;
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
        end
        e.a  = m_a;
        e.d  = m_d;
        e.pc = m_pc;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            post_pending = 1'b0;
        end else begin
            if (post_pending) begin
                check("pc", 32'(ifc.pc), 32'(post.pc));
                check("d", 32'(alu_x), 32'(post.d));
                check("a", 32'(alu_y), 32'(post.a));
                post_pending = 1'b0;
            end
            if (writeM) begin
                wr_cnt++;
                last_wr_addr = addressM;
                last_wr_data = outM;
                check("wm_in_wb", 32'(retired), 32'd1);
            end
            if (retired) begin
                retire_cnt++;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    post = sb.pop_front();
                    check("writeM", 32'(writeM), 32'(post.wr));
                    if (post.wr) begin
                        check("outM", 32'(outM), 32'(post.data));
                        check("addressM", 32'(addressM), 32'(post.addr));
                    end
                    post_pending = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [15:0] ins);
        exp_t        e;
        int unsigned n0;
        bit          ok;
        model_step(ins, e);
        sb.push_back(e);
        n0 = retire_cnt;
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        ifc.instr       = ins;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ifc.instr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            ifc.instr_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        ifc.instr       = 16'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (retire_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("retire_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        m_a  = '0;
        m_d  = '0;
        m_pc = '0;
        sb.delete();
        #1;
        check("rst_ready0", 32'(ifc.instr_ready), 32'd0);
        check("rst_pc", 32'(ifc.pc), 32'd0);
        check("rst_writeM", 32'(writeM), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_a", 32'(alu_y), 32'd0);
        check("rst_d", 32'(alu_x), 32'd0);
        check("rst_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
        @(posedge clk);
        #1;
        check("rst_ready1", 32'(ifc.instr_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0;
        bit          ok;
        ifc.instr_valid = 1'b0;
        ifc.instr       = '0;
        repeat (3) @(posedge clk);
        reset_release();

        // @21 ; D=A
        r0 = retire_cnt;
        send(16'h0015);
        send(16'hEC10);
        check("t2_d", 32'(alu_x), 32'd21);
        check("t2_pc", 32'(ifc.pc), 32'd2);
        check("t2_retires", retire_cnt - r0, 32'd2);
        check("t2_nowrite", wr_cnt, 32'd0);

        // @100 ; M=D+1
        send(16'd100);
        send(16'hE7C8);
        check("t3_wrcnt", wr_cnt, 32'd1);
        check("t3_outM", 32'(last_wr_data), 32'd22);
        check("t3_addr", 32'(last_wr_addr), 32'd100);
        check("t3_mem", 32'(mem[100]), 32'd22);

        // Conditional jumps on D
        send(16'hEA90);
        send(16'd7);
        send(16'hE302);
        check("t4_jeq_taken", 32'(ifc.pc), 32'd7);
        send(16'd5);
        send(16'hEC10);
        send(16'd7);
        send(16'hE302);
        check("t4_jeq_not", 32'(ifc.pc), 32'd11);
        send(16'hEE90);
        send(16'd7);
        send(16'hE304);
        check("t4_jlt_taken", 32'(ifc.pc), 32'd7);

        // AM=M-1 with A=50, M=9
        send(16'd50);
        send(16'hFCA8);
        check("t5_outM", 32'(last_wr_data), 32'd8);
        check("t5_addr", 32'(last_wr_addr), 32'd50);
        check("t5_a", 32'(alu_y), 32'd8);
        check("t5_mem", 32'(mem[50]), 32'd8);

        // PC wrap: jump to 0x7FFF then an A-instruction
        send(16'h7FFF);
        send(16'hEA87);
        check("wrap_top", 32'(ifc.pc), 32'h7FFF);
        send(16'h0000);
        check("wrap_zero", 32'(ifc.pc), 32'd0);

        // Reset while M=1 is in EXEC
        send(16'd100);
        check("pre_rst_pc", 32'(ifc.pc), 32'd1);
        @(negedge clk);
        ifc.instr_valid = 1'b1;
        ifc.instr       = 16'hEFC8;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ifc.instr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("exec_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
        check("exec_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'h3F);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_pc", 32'(ifc.pc), 32'd0);
        check("arst_writeM", 32'(writeM), 32'd0);
        check("arst_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_wm", 32'(writeM), 32'd0);
        reset_release();
        check("arst_mem_kept", 32'(mem[100]), 32'd22);

        // Random instruction stream with idle gaps and garbage on instr
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                ifc.instr = 16'($urandom);
            end
            send(16'($urandom));
        end
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
